// File: rtl/boot_bus_translator.sv
// rtl/boot_bus_translator.sv - boot control payload requests to AHB-Lite INCR4 bursts
module boot_bus_translator #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bootControl_bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
  input  logic                          bootControl_bus_RW,
  output logic                          bootControl_bus_done,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
  output logic                          bootControl_bus_err,
  output logic                          bootControl_bus_busy,
  output logic [pAHB_ADDR_WIDTH-1:0]    HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [pAHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic [pAHB_DATA_WIDTH-1:0]    HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);

  localparam int LP_BEATS = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
  localparam int LP_BW    = (LP_BEATS > 1) ? $clog2(LP_BEATS) : 1;
  localparam int LP_BYTES = pAHB_DATA_WIDTH / 8;
  localparam int LP_ALIGN = $clog2(pPAYLOAD_SIZE_BITS / 8);
  localparam logic [pAHB_ADDR_WIDTH-1:0] LP_ALIGN_MASK = ~pAHB_ADDR_WIDTH'((1 << LP_ALIGN) - 1);
  localparam logic [1:0] LP_TR_IDLE   = 2'b00;
  localparam logic [1:0] LP_TR_NONSEQ = 2'b10;
  localparam logic [1:0] LP_TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR0, S_BURST, S_LASTDATA, S_DONE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [pAHB_ADDR_WIDTH-1:0]    r_addr, w_addr_nxt;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_payload, w_payload_nxt;
  logic                          r_rw, w_rw_nxt;
  logic [LP_BW-1:0]              r_beat, w_beat_nxt;
  logic                          r_abort, w_abort_nxt;
  logic [pAHB_ADDR_WIDTH-1:0]    r_haddr, w_haddr_nxt;
  logic [1:0]                    r_htrans, w_htrans_nxt;
  logic                          r_hwrite, w_hwrite_nxt;
  logic [pAHB_DATA_WIDTH-1:0]    r_hwdata, w_hwdata_nxt;
  logic                          r_err, w_err_nxt;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_rd_data, w_rd_data_nxt;
  logic                          r_done, r_busy;

  // r_beat is the beat whose address phase is on the bus; its data phase trails by one.
  logic [LP_BW-1:0]              w_beat_inc, w_beat_dec;
  logic [pAHB_ADDR_WIDTH-1:0]    w_addr_inc;
  logic [pAHB_DATA_WIDTH-1:0]    w_word_cur;
  logic                          w_last;

  assign w_beat_inc = r_beat + LP_BW'(1);
  assign w_beat_dec = r_beat - LP_BW'(1);
  assign w_addr_inc = r_addr + pAHB_ADDR_WIDTH'(w_beat_inc) * pAHB_ADDR_WIDTH'(LP_BYTES);
  assign w_word_cur = r_payload[int'(r_beat)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
  assign w_last     = (r_beat == LP_BW'(LP_BEATS - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_payload_nxt = r_payload;
    w_rw_nxt      = r_rw;
    w_beat_nxt    = r_beat;
    w_abort_nxt   = r_abort;
    w_haddr_nxt   = r_haddr;
    w_htrans_nxt  = r_htrans;
    w_hwrite_nxt  = r_hwrite;
    w_hwdata_nxt  = r_hwdata;
    w_err_nxt     = r_err;
    w_rd_data_nxt = r_rd_data;
    case (r_state)
      S_IDLE: begin
        if (bootControl_bus_go) begin
          w_state_nxt   = S_ADDR0;
          w_addr_nxt    = bootControl_bus_addr & LP_ALIGN_MASK;
          w_payload_nxt = bootControl_bus_write;
          w_rw_nxt      = bootControl_bus_RW;
          w_beat_nxt    = '0;
          w_abort_nxt   = 1'b0;
          w_err_nxt     = 1'b0;
          w_haddr_nxt   = bootControl_bus_addr & LP_ALIGN_MASK;
          w_htrans_nxt  = LP_TR_NONSEQ;
          w_hwrite_nxt  = bootControl_bus_RW;
        end
      end
      S_ADDR0: begin
        if (HREADY) begin
          w_state_nxt  = S_BURST;
          w_beat_nxt   = w_beat_inc;
          w_haddr_nxt  = w_addr_inc;
          w_htrans_nxt = LP_TR_SEQ;
          w_hwdata_nxt = w_word_cur;
        end
      end
      S_BURST: begin
        // An ERROR response cancels the pending address phase by dropping to IDLE.
        if (HRESP) begin
          w_htrans_nxt = LP_TR_IDLE;
          if (HREADY) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_LASTDATA;
            w_abort_nxt = 1'b1;
          end
        end else if (HREADY) begin
          if (!r_rw) begin
            w_rd_data_nxt[int'(w_beat_dec)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] = HRDATA;
          end
          w_hwdata_nxt = w_word_cur;
          if (w_last) begin
            w_state_nxt  = S_LASTDATA;
            w_htrans_nxt = LP_TR_IDLE;
          end else begin
            w_beat_nxt  = w_beat_inc;
            w_haddr_nxt = w_addr_inc;
          end
        end
      end
      S_LASTDATA: begin
        if (HREADY) begin
          w_state_nxt = S_DONE;
          if (HRESP || r_abort) begin
            w_err_nxt = 1'b1;
          end else if (!r_rw) begin
            w_rd_data_nxt[int'(r_beat)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] = HRDATA;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_payload <= '0;
      r_rw      <= 1'b0;
      r_beat    <= '0;
      r_abort   <= 1'b0;
      r_haddr   <= '0;
      r_htrans  <= LP_TR_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_payload <= w_payload_nxt;
      r_rw      <= w_rw_nxt;
      r_beat    <= w_beat_nxt;
      r_abort   <= w_abort_nxt;
      r_haddr   <= w_haddr_nxt;
      r_htrans  <= w_htrans_nxt;
      r_hwrite  <= w_hwrite_nxt;
      r_hwdata  <= w_hwdata_nxt;
      r_err     <= w_err_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_done    <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign bootControl_bus_done   = r_done;
  assign bootControl_bus_rdData = r_rd_data;
  assign bootControl_bus_err    = r_err;
  assign bootControl_bus_busy   = r_busy;
  assign HADDR                  = r_haddr;
  assign HTRANS                 = r_htrans;
  assign HWRITE                 = r_hwrite;
  assign HWDATA                 = r_hwdata;
  assign HSIZE                  = 3'b010;
  assign HBURST                 = 3'b011;

endmodule
